// File: rtl/adder8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder8_pkg
//  Description : Shared constants for the adder8 bus responder: opcodes,
//                FSM state encoding, uio pin bit indices and the fixed uio
//                output-enable mask.
//  Revision    : 1.0  initial release
// ============================================================================
package adder8_pkg;

    // Opcodes carried on uio_in[2:1]
    localparam logic [1:0] OP_LOAD_A = 2'b00;
    localparam logic [1:0] OP_LOAD_B = 2'b01;
    localparam logic [1:0] OP_ADD    = 2'b10;
    localparam logic [1:0] OP_ACC    = 2'b11;

    // Responder FSM state encoding
    localparam int         STATE_W = 2;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_ACK   = 2'd2;

    // uio pin bit indices
    localparam int REQ   = 0;
    localparam int OP_LO = 1;
    localparam int ACK   = 3;
    localparam int CARRY = 4;
    localparam int BUSY  = 5;

    // Bits 3..5 of uio are driven by this design
    localparam logic [7:0] UIO_OE_MASK = 8'h38;

endpackage
`default_nettype wire

// File: rtl/adder8_serial_core.sv
`default_nettype none
// ============================================================================
//  Module      : adder8_serial_core
//  Description : Slice adder for the serial add. Each step adds one STEP-bit
//                slice of A and B plus the carry held from the previous
//                slice. i_clear zeroes the held carry before a new add.
//  Ports       : clk, rst          clock / sync active-high reset
//                i_clear           zero the held carry
//                i_step            commit this slice's carry-out
//                i_a_slice/i_b_slice  operand slices (STEP bits)
//                o_sum_slice       sum slice (combinational)
//                o_carry           carry-out of this slice (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module adder8_serial_core #(
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clear,
    input  logic            i_step,
    input  logic [STEP-1:0] i_a_slice,
    input  logic [STEP-1:0] i_b_slice,
    output logic [STEP-1:0] o_sum_slice,
    output logic            o_carry
);

    logic            r_carry;
    logic [STEP:0]   w_total;

    assign w_total     = {1'b0, i_a_slice} + {1'b0, i_b_slice} + {{STEP{1'b0}}, r_carry};
    assign o_sum_slice = w_total[STEP-1:0];
    assign o_carry     = w_total[STEP];

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_carry <= 1'b0;
        end else if (i_step) begin
            r_carry <= w_total[STEP];
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder8_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : adder8_bus_responder
//  Description : Responder side of the adder8 four-phase operand/result
//                handshake. Loads A/B, or runs a serial STEP-bit-per-cycle
//                add (ADD / ACC), then acks with the result on uo_out.
//  Ports       : clk, rst   clock / sync active-high reset
//                ena        design selected; gates acceptance only
//                ui_in      operand byte
//                uo_out     result register
//                uio_in     [0] req, [2:1] op
//                uio_out    [3] ack, [4] carry, [5] busy
//                uio_oe     constant 8'h38
//  Revision    : 1.0  initial release
// ============================================================================
module adder8_bus_responder
    import adder8_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int         c_slices = 8 / STEP;
    localparam logic [2:0] c_last   = 3'(c_slices - 1);

    logic [STATE_W-1:0] r_state, w_state_next;
    logic [2:0]         r_cnt, w_cnt_next;
    logic [7:0]         r_a, w_a_next;
    logic [7:0]         r_b, w_b_next;
    logic [7:0]         r_sa, w_sa_next;      // A slices out, sum slices in
    logic [7:0]         r_sb, w_sb_next;
    logic [7:0]         r_result, w_result_next;
    logic [1:0]         r_op, w_op_next;
    logic               r_carry, w_carry_next;
    logic               r_req_seen_low, w_req_seen_low_next;

    logic               w_req;
    logic [1:0]         w_op;
    logic               w_core_clear;
    logic               w_core_step;
    logic [STEP-1:0]    w_core_sum;
    logic               w_core_cout;
    logic [7:0]         w_sa_shift;
    logic               w_unused;

    assign w_req    = uio_in[REQ];
    assign w_op     = uio_in[OP_LO +: 2];
    assign w_unused = &{1'b0, uio_in[7:3]};

    adder8_serial_core #(
        .STEP (STEP)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_core_clear),
        .i_step      (w_core_step),
        .i_a_slice   (r_sa[STEP-1:0]),
        .i_b_slice   (r_sb[STEP-1:0]),
        .o_sum_slice (w_core_sum),
        .o_carry     (w_core_cout)
    );

    // The A shift register doubles as the sum collector: each consumed A
    // slice leaves the bottom while the matching sum slice enters the top,
    // so after the last slice r_sa's next value is the full sum.
    if (STEP == 8) begin : g_whole
        assign w_sa_shift = w_core_sum;
    end else begin : g_slice
        assign w_sa_shift = {w_core_sum, r_sa[7:STEP]};
    end

    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt;
        w_a_next            = r_a;
        w_b_next            = r_b;
        w_sa_next           = r_sa;
        w_sb_next           = r_sb;
        w_result_next       = r_result;
        w_op_next           = r_op;
        w_carry_next        = r_carry;
        // Any low sample of req re-arms acceptance.
        w_req_seen_low_next = r_req_seen_low | ~w_req;
        w_core_clear        = 1'b0;
        w_core_step         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (ena && w_req && r_req_seen_low) begin
                    w_req_seen_low_next = 1'b0;
                    w_op_next           = w_op;
                    case (w_op)
                        OP_LOAD_A: begin
                            w_a_next     = ui_in;
                            w_state_next = S_ACK;
                        end
                        OP_LOAD_B: begin
                            w_b_next     = ui_in;
                            w_state_next = S_ACK;
                        end
                        default: begin
                            w_sa_next    = r_a;
                            w_sb_next    = r_b;
                            w_cnt_next   = 3'd0;
                            w_core_clear = 1'b1;
                            w_state_next = S_CALC;
                        end
                    endcase
                end
            end
            S_CALC: begin
                w_core_step = 1'b1;
                w_sa_next   = w_sa_shift;
                w_sb_next   = r_sb >> STEP;
                w_cnt_next  = r_cnt + 3'd1;
                if (r_cnt == c_last) begin
                    w_result_next = w_sa_shift;
                    w_carry_next  = w_core_cout;
                    if (r_op == OP_ACC) begin
                        w_a_next = w_sa_shift;
                    end
                    w_cnt_next   = 3'd0;
                    w_state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (!w_req) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= 3'd0;
            r_a            <= 8'h00;
            r_b            <= 8'h00;
            r_sa           <= 8'h00;
            r_sb           <= 8'h00;
            r_result       <= 8'h00;
            r_op           <= OP_LOAD_A;
            r_carry        <= 1'b0;
            r_req_seen_low <= 1'b1;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_a            <= w_a_next;
            r_b            <= w_b_next;
            r_sa           <= w_sa_next;
            r_sb           <= w_sb_next;
            r_result       <= w_result_next;
            r_op           <= w_op_next;
            r_carry        <= w_carry_next;
            r_req_seen_low <= w_req_seen_low_next;
        end
    end

    always_comb begin
        uio_out        = 8'h00;
        uio_out[ACK]   = (r_state == S_ACK);
        uio_out[CARRY] = r_carry;
        uio_out[BUSY]  = (r_state == S_CALC);
    end

    assign uo_out = r_result;
    assign uio_oe = UIO_OE_MASK;

endmodule
`default_nettype wire

// File: tb/tb_adder8_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder8_bus_responder
//  Description : Testbench for adder8_bus_responder. Four instances with
//                STEP = 1, 2, 4, 8 share clk/rst/ena; each has its own
//                handshake pins. A transaction-level model predicts the
//                pins every cycle; directed literal checks pin the model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adder8_bus_responder;

    localparam int         N_DUT     = 4;
    localparam logic [1:0] OP_LOAD_A = 2'b00;
    localparam logic [1:0] OP_LOAD_B = 2'b01;
    localparam logic [1:0] OP_ADD    = 2'b10;
    localparam logic [1:0] OP_ACC    = 2'b11;
    localparam int         M_IDLE    = 0;
    localparam int         M_BUSY    = 1;
    localparam int         M_ACK     = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in_a   [N_DUT];
    logic [7:0] uio_in_a  [N_DUT];
    logic [7:0] uo_out_a  [N_DUT];
    logic [7:0] uio_out_a [N_DUT];
    logic [7:0] uio_oe_a  [N_DUT];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        adder8_bus_responder #(
            .STEP (1 << gi)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .ena     (ena),
            .ui_in   (ui_in_a[gi]),
            .uo_out  (uo_out_a[gi]),
            .uio_in  (uio_in_a[gi]),
            .uio_out (uio_out_a[gi]),
            .uio_oe  (uio_oe_a[gi])
        );
    end

    // ------------------------------------------------------------------
    // Transaction-level model: tracks A, B, result, carry and whether the
    // responder is idle, busy (cycles left) or acknowledging.
    // ------------------------------------------------------------------
    logic [7:0] m_a [N_DUT];
    logic [7:0] m_b [N_DUT];
    logic [7:0] m_res [N_DUT];
    logic       m_cy [N_DUT];
    logic       m_seen [N_DUT];
    logic [1:0] m_op [N_DUT];
    int         m_mode [N_DUT];
    int         m_left [N_DUT];
    bit         started = 1'b0;

    always @(posedge clk) begin
        for (int d = 0; d < N_DUT; d++) begin : b_model
            logic       rq;
            logic [1:0] o;
            logic [8:0] s;
            if (rst) begin
                m_a[d] = 8'h00; m_b[d] = 8'h00; m_res[d] = 8'h00;
                m_cy[d] = 1'b0; m_seen[d] = 1'b1; m_op[d] = 2'b00;
                m_mode[d] = M_IDLE; m_left[d] = 0;
                started = 1'b1;
            end else begin
                rq = uio_in_a[d][0];
                o  = uio_in_a[d][2:1];
                case (m_mode[d])
                    M_IDLE: begin
                        if (ena && rq && m_seen[d]) begin
                            m_seen[d] = 1'b0;
                            if (o == OP_LOAD_A) begin
                                m_a[d] = ui_in_a[d]; m_mode[d] = M_ACK;
                            end else if (o == OP_LOAD_B) begin
                                m_b[d] = ui_in_a[d]; m_mode[d] = M_ACK;
                            end else begin
                                m_op[d] = o; m_left[d] = 8 >> d; m_mode[d] = M_BUSY;
                            end
                        end
                    end
                    M_BUSY: begin
                        m_left[d] = m_left[d] - 1;
                        if (m_left[d] == 0) begin
                            s = {1'b0, m_a[d]} + {1'b0, m_b[d]};
                            m_res[d] = s[7:0];
                            m_cy[d]  = s[8];
                            if (m_op[d] == OP_ACC) m_a[d] = s[7:0];
                            m_mode[d] = M_ACK;
                        end
                    end
                    default: begin
                        if (!rq) m_mode[d] = M_IDLE;
                    end
                endcase
                if (!rq) m_seen[d] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < N_DUT; d++) begin
                logic [7:0] exp_uio;
                exp_uio = {2'b00, m_mode[d] == M_BUSY, m_cy[d], m_mode[d] == M_ACK, 3'b000};
                checks++;
                if (uo_out_a[d] !== m_res[d] || uio_out_a[d] !== exp_uio || uio_oe_a[d] !== 8'h38) begin
                    errors++;
                    $display("FAIL model_cmp dut%0d t=%0t: got uo=%h uio_out=%h oe=%h, want uo=%h uio_out=%h oe=38",
                             d, $time, uo_out_a[d], uio_out_a[d], uio_oe_a[d], m_res[d], exp_uio);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic chk8(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h, want %h", name, d, act, exp);
        end
    endtask

    function automatic logic [7:0] req_word(input logic [1:0] op, input logic req);
        return {5'b00000, op, req};
    endfunction

    // Full four-phase transaction; checks ack latency and ack release.
    task automatic txn(input int d, input logic [1:0] op, input logic [7:0] data,
                       output logic [7:0] res, output logic cy);
        int lat;
        bit got;
        int exp_lat;
        @(negedge clk);
        ui_in_a[d]  = data;
        uio_in_a[d] = req_word(op, 1'b1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (uio_out_a[d][3]) got = 1'b1;
        end
        exp_lat = op[1] ? 1 + (8 >> d) : 1;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout dut%0d: no ack after %0d cycles, want ack at %0d", d, lat, exp_lat);
        end else if (lat != exp_lat) begin
            errors++;
            $display("FAIL ack_latency dut%0d: got %0d, want %0d", d, lat, exp_lat);
        end
        res = uo_out_a[d];
        cy  = uio_out_a[d][4];
        uio_in_a[d] = req_word(op, 1'b0);
        @(negedge clk);
        chk8("ack_release", d, {7'b0, uio_out_a[d][3]}, 8'h00);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] res;
        logic       cy;
        int         ack_cycles;
        logic [7:0] ack_res;

        rst = 1'b1;
        ena = 1'b1;
        for (int d = 0; d < N_DUT; d++) begin
            ui_in_a[d]  = 8'h00;
            uio_in_a[d] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < N_DUT; d++) begin
            chk8("rst_uo", d, uo_out_a[d], 8'h00);
            chk8("rst_uio_out", d, uio_out_a[d], 8'h00);
            chk8("rst_uio_oe", d, uio_oe_a[d], 8'h38);
        end
        rst = 1'b0;

        // req with ena=0 is never accepted
        @(negedge clk);
        ena = 1'b0;
        for (int d = 0; d < N_DUT; d++) begin
            ui_in_a[d] = 8'h77;
            uio_in_a[d] = req_word(OP_LOAD_A, 1'b1);
        end
        repeat (4) @(negedge clk);
        for (int d = 0; d < N_DUT; d++) begin
            chk8("ena0_no_ack", d, uio_out_a[d], 8'h00);
            uio_in_a[d] = 8'h00;
        end
        ena = 1'b1;

        // basic ADD / ACC sequences on every STEP
        for (int d = 0; d < N_DUT; d++) begin
            txn(d, OP_LOAD_A, 8'h12, res, cy);
            txn(d, OP_LOAD_B, 8'h34, res, cy);
            txn(d, OP_ADD, 8'h00, res, cy);
            chk8("add_12_34", d, res, 8'h46);
            chk8("add_12_34_cy", d, {7'b0, cy}, 8'h00);
            txn(d, OP_ADD, 8'hEE, res, cy);
            chk8("add_again_a_kept", d, res, 8'h46);
            txn(d, OP_LOAD_A, 8'hFF, res, cy);
            chk8("load_keeps_res", d, res, 8'h46);
            txn(d, OP_LOAD_B, 8'h01, res, cy);
            txn(d, OP_ADD, 8'h00, res, cy);
            chk8("wrap_ff_01", d, res, 8'h00);
            chk8("wrap_ff_01_cy", d, {7'b0, cy}, 8'h01);
            txn(d, OP_LOAD_B, 8'h80, res, cy);
            txn(d, OP_ACC, 8'h00, res, cy);
            chk8("acc1", d, res, 8'h7F);
            chk8("acc1_cy", d, {7'b0, cy}, 8'h01);
            txn(d, OP_ACC, 8'h00, res, cy);
            chk8("acc2", d, res, 8'hFF);
            chk8("acc2_cy", d, {7'b0, cy}, 8'h00);
        end

        // req dropped mid-CALC, inputs toggled, ena dropped: still completes
        for (int d = 0; d < 3; d++) begin
            txn(d, OP_LOAD_A, 8'h3C, res, cy);
            txn(d, OP_LOAD_B, 8'h0F, res, cy);
            @(negedge clk);
            uio_in_a[d] = req_word(OP_ADD, 1'b1);
            @(negedge clk);
            uio_in_a[d] = req_word(OP_LOAD_B, 1'b1);
            ui_in_a[d]  = 8'hEE;
            @(negedge clk);
            uio_in_a[d] = req_word(OP_LOAD_A, 1'b0);
            ena = 1'b0;
            ack_cycles = 0;
            ack_res = 8'h00;
            repeat (12) begin
                @(negedge clk);
                if (uio_out_a[d][3]) begin
                    ack_cycles++;
                    ack_res = uo_out_a[d];
                end
            end
            ena = 1'b1;
            chk8("drop_req_ack_cycles", d, 8'(ack_cycles), 8'h01);
            chk8("drop_req_res", d, ack_res, 8'h4B);
        end

        // reset mid-CALC at cnt=4 on the STEP=1 instance
        @(negedge clk);
        uio_in_a[0] = req_word(OP_ADD, 1'b1);
        repeat (5) @(negedge clk);
        chk8("busy_before_rst", 0, {7'b0, uio_out_a[0][5]}, 8'h01);
        rst = 1'b1;
        uio_in_a[0] = 8'h00;
        @(negedge clk);
        for (int d = 0; d < N_DUT; d++) begin
            chk8("midcalc_rst_uo", d, uo_out_a[d], 8'h00);
            chk8("midcalc_rst_uio", d, uio_out_a[d], 8'h00);
        end
        rst = 1'b0;
        for (int d = 0; d < N_DUT; d++) begin
            txn(d, OP_ADD, 8'h55, res, cy);
            chk8("post_rst_add", d, res, 8'h00);
            chk8("post_rst_add_cy", d, {7'b0, cy}, 8'h00);
        end

        // STEP sweep A5+5B, req held high through ACK: no second transaction
        for (int d = 0; d < N_DUT; d++) begin
            bit got;
            int lat;
            txn(d, OP_LOAD_A, 8'hA5, res, cy);
            txn(d, OP_LOAD_B, 8'h5B, res, cy);
            @(negedge clk);
            uio_in_a[d] = req_word(OP_ADD, 1'b1);
            got = 1'b0;
            lat = 0;
            while (!got && lat < 40) begin
                @(negedge clk);
                lat++;
                if (uio_out_a[d][3]) got = 1'b1;
            end
            chk8("sweep_latency", d, 8'(lat), 8'(1 + (8 >> d)));
            chk8("sweep_res", d, uo_out_a[d], 8'h00);
            chk8("sweep_cy", d, {7'b0, uio_out_a[d][4]}, 8'h01);
            uio_in_a[d] = req_word(OP_ACC, 1'b1);
            repeat (6) @(negedge clk);
            chk8("hold_ack_high", d, {7'b0, uio_out_a[d][3]}, 8'h01);
            chk8("hold_not_busy", d, {7'b0, uio_out_a[d][5]}, 8'h00);
            uio_in_a[d] = req_word(OP_ACC, 1'b0);
            @(negedge clk);
            chk8("hold_release", d, {7'b0, uio_out_a[d][3]}, 8'h00);
            txn(d, OP_ADD, 8'h00, res, cy);
            chk8("hold_a_unchanged", d, res, 8'h00);
        end

        // randomized transactions, checked every cycle by the model
        for (int n = 0; n < 12; n++) begin
            for (int d = 0; d < N_DUT; d++) begin
                logic [1:0] rop;
                rop = 2'($urandom_range(0, 3));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                txn(d, rop, 8'($urandom), res, cy);
            end
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
